// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: result = value_1 - value_2 (mod 2^WIDTH).
// One full-subtractor cell plus a borrow flop, LSB first, one bit per clock.
// There is a valid/ready handshake on the operand side and on the result side.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | waiting for operands; in_ready=1
// ST_RUN  | shifting operands through the subtractor cell, one bit/clock
// ST_DONE | result/borrow presented; held until out_ready
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] value_1,
    input  logic [WIDTH-1:0] value_2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             borrow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [WIDTH-1:0] res_q,    res_d;
    logic             br_q,     br_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q,    cnt_d;

    logic bit_a;
    logic bit_b;
    logic diff_bit;
    logic br_next;

    // Register all state; synchronous reset wins over any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            br_q     <= 1'b0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            br_q     <= br_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
        end
    end

    // Full-subtractor cell, next-state logic and handshake outputs.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        br_d      = br_q;
        borrow_d  = borrow_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        bit_a    = a_q[0];
        bit_b    = b_q[0];
        diff_bit = bit_a ^ bit_b ^ br_q;
        br_next  = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_q);

        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = value_1;
                    b_d     = value_2;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Difference bits enter at the MSB so that after WIDTH
                // shifts the LSB-first stream sits in natural bit order.
                // The shift form also stays legal for WIDTH=1.
                res_d = (res_q >> 1) | (WIDTH'(diff_bit) << (WIDTH - 1));
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = br_next;
                if (cnt_q == LAST_BIT) begin
                    borrow_d = br_next;
                    state_d  = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign result = res_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed and random checks at WIDTH=8, plus
// random sweeps of WIDTH=1 and WIDTH=16 instances running alongside.
module tb_serial_subtractor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Count one comparison and report it if it does not match.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- WIDTH = 8 instance ----------------
    logic       rst8, iv8, ir8, ov8, or8, br8;
    logic [7:0] v1_8, v2_8, res8;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst8),
        .in_valid  (iv8),
        .in_ready  (ir8),
        .value_1   (v1_8),
        .value_2   (v2_8),
        .out_valid (ov8),
        .out_ready (or8),
        .result    (res8),
        .borrow    (br8)
    );

    // One complete operation with an optional out_ready stall in DONE.
    task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input int stall);
        logic [7:0] er;
        logic       eb;
        int         lat;
        er  = 8'((int'(a) - int'(b)) & 255);
        eb  = (int'(a) < int'(b));
        lat = 0;
        while (!ir8 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("op_idle_ready", ir8, 1);
        v1_8 = a;
        v2_8 = b;
        iv8  = 1'b1;
        or8  = (stall == 0);
        @(negedge clk);
        iv8 = 1'b0;
        chk("run_in_ready", ir8, 0);
        lat = 0;
        while (!ov8 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, 8);
        chk("result", res8, er);
        chk("borrow", br8, eb);
        chk("done_in_ready", ir8, 0);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("stall_valid", ov8, 1);
            chk("stall_in_ready", ir8, 0);
            chk("stall_result", res8, er);
            chk("stall_borrow", br8, eb);
            iv8  = 1'($urandom);
            v1_8 = 8'($urandom);
            v2_8 = 8'($urandom);
        end
        iv8 = 1'b0;
        or8 = 1'b1;
        @(negedge clk);
        chk("back_idle_valid", ov8, 0);
        chk("back_idle_ready", ir8, 1);
    endtask

    // ---------------- WIDTH = 1 and WIDTH = 16 instances ----------------
    for (genvar g = 0; g < 2; g++) begin : g_w
        localparam int GW = (g == 0) ? 1 : 16;
        logic          rst_g, iv_g, ir_g, ov_g, or_g, br_g, gen_done;
        logic [GW-1:0] a_g, b_g, res_g;

        serial_subtractor #(.WIDTH(GW)) u_dut (
            .clk       (clk),
            .rst       (rst_g),
            .in_valid  (iv_g),
            .in_ready  (ir_g),
            .value_1   (a_g),
            .value_2   (b_g),
            .out_valid (ov_g),
            .out_ready (or_g),
            .result    (res_g),
            .borrow    (br_g)
        );

        // Random sweep against plain modular arithmetic.
        initial begin
            logic [GW-1:0] x, y, er;
            logic          ebr;
            int            lat;
            gen_done = 1'b0;
            rst_g    = 1'b1;
            iv_g     = 1'b0;
            or_g     = 1'b1;
            a_g      = '0;
            b_g      = '0;
            repeat (2) @(negedge clk);
            chk("w_rst_ready", ir_g, 1);
            chk("w_rst_valid", ov_g, 0);
            chk("w_rst_result", res_g, 0);
            rst_g = 1'b0;
            for (int n = 0; n < 100; n++) begin
                x = GW'($urandom);
                y = GW'($urandom);
                if (n == 0) begin
                    x = '0;
                    y = '1;
                end
                er  = GW'(int'(x) - int'(y) + (1 << GW));
                ebr = (int'(x) < int'(y));
                a_g  = x;
                b_g  = y;
                iv_g = 1'b1;
                @(negedge clk);
                iv_g = 1'b0;
                lat  = 0;
                while (!ov_g && lat < 40) begin
                    @(negedge clk);
                    lat++;
                end
                chk("w_latency", lat, GW);
                chk("w_result", res_g, er);
                chk("w_borrow", br_g, ebr);
                @(negedge clk);
                chk("w_back_idle", ov_g, 0);
            end
            gen_done = 1'b1;
        end
    end

    // Directed WIDTH=8 sequence, random sweep, then the summary.
    initial begin
        logic [7:0] bb_a [3];
        logic [7:0] bb_b [3];
        logic [7:0] bb_r [3];
        logic       bb_c [3];
        int k, cyc, last, wt;

        bb_a = '{8'd10, 8'd4, 8'd200};
        bb_b = '{8'd4, 8'd10, 8'd100};
        bb_r = '{8'h06, 8'hFA, 8'h64};
        bb_c = '{1'b0, 1'b1, 1'b0};

        rst8 = 1'b1;
        iv8  = 1'b0;
        or8  = 1'b0;
        v1_8 = 8'h00;
        v2_8 = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", ir8, 1);
        chk("rst_out_valid", ov8, 0);
        chk("rst_result", res8, 0);
        chk("rst_borrow", br8, 0);
        rst8 = 1'b0;
        @(negedge clk);

        run_op8(8'd5, 8'd3, 0);
        run_op8(8'd3, 8'd5, 0);
        run_op8(8'h00, 8'h01, 0);
        run_op8(8'h00, 8'h00, 0);
        run_op8(8'hFF, 8'hFF, 0);
        run_op8(8'h37, 8'h52, 5);

        // Reset landing on the 4th RUN edge of A0-0F.
        v1_8 = 8'hA0;
        v2_8 = 8'h0F;
        iv8  = 1'b1;
        or8  = 1'b1;
        @(negedge clk);
        iv8 = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_running", ov8, 0);
        rst8 = 1'b1;
        @(negedge clk);
        rst8 = 1'b0;
        chk("midrst_in_ready", ir8, 1);
        chk("midrst_out_valid", ov8, 0);
        chk("midrst_result", res8, 0);
        chk("midrst_borrow", br8, 0);
        run_op8(8'hA0, 8'h0F, 0);

        // Back-to-back with in_valid held high.
        v1_8 = bb_a[0];
        v2_8 = bb_b[0];
        iv8  = 1'b1;
        or8  = 1'b1;
        k    = 0;
        cyc  = 0;
        last = 0;
        while (k < 3 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            chk("b2b_exclusive", {31'b0, ir8 & ov8}, 0);
            if (ov8) begin
                chk("b2b_result", res8, bb_r[k]);
                chk("b2b_borrow", br8, bb_c[k]);
                if (k > 0) chk("b2b_spacing", cyc - last, 10);
                last = cyc;
                k++;
                if (k < 3) begin
                    v1_8 = bb_a[k];
                    v2_8 = bb_b[k];
                end else begin
                    iv8 = 1'b0;
                end
            end
        end
        iv8 = 1'b0;
        chk("b2b_count", k, 3);
        @(negedge clk);

        for (int n = 0; n < 200; n++) begin
            run_op8(8'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
        end

        wt = 0;
        while (!(g_w[0].gen_done && g_w[1].gen_done) && wt < 20000) begin
            @(negedge clk);
            wt++;
        end
        chk("sweeps_finished", {31'b0, g_w[0].gen_done & g_w[1].gen_done}, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, multi-bit subtractor. Computes result = value_1 - value_2 (mod 2^WIDTH) and a borrow-out.
- Processes one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop.
- Valid/ready handshake on both input and output, so it drops into datapaths where area matters more than latency.
- Counterpart to the team's combinational 1-bit XOR adder cell.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range WIDTH >= 1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands on value_1/value_2 are valid.
- in_ready  output  1  block can accept operands this cycle.
- value_1  input  WIDTH  minuend.
- value_2  input  WIDTH  subtrahend.
- out_valid  output  1  result/borrow are valid.
- out_ready  input  1  consumer accepts the result this cycle.
- result  output  WIDTH  difference, value_1 - value_2 mod 2^WIDTH.
- borrow  output  1  1 when value_1 < value_2 (unsigned).

Behaviour:
- Reset (rst=1 at a rising edge) applies regardless of state, including mid-operation; any in-flight operation is discarded.
  - Next state: IDLE; in_ready=1, out_valid=0, result=0, borrow=0.
  - Internal operand shift registers, borrow flop and bit counter are cleared.
- State machine has three states:
  - IDLE: in_ready=1, out_valid=0. If in_valid=1 at an edge (accept): latch value_1 and value_2 into shift registers, clear the borrow flop, set the counter to 0, go to RUN.
  - RUN: in_ready=0, out_valid=0. Each edge processes the LSBs a, b of the shift registers with borrow flop br:
    - d = a ^ b ^ br
    - br_next = (~a & b) | (~(a ^ b) & br)
    - d is shifted into the result register at the MSB end, shifting right; operand registers shift right by 1; counter increments.
    - When the counter reaches WIDTH-1 at the edge (the last bit), go to DONE and load the final br_next into borrow.
  - DONE: out_valid=1, in_ready=0. result and borrow are held stable. If out_ready=1 at an edge, go to IDLE.
- Timing:
  - Latency: with acceptance at edge T, out_valid=1 is visible after edge T+WIDTH.
  - Throughput: at most one operation per WIDTH+2 cycles; no input/output overlap.
  - in_ready and out_valid are never both 1.
- The result register holds its value through IDLE until the next operation's first RUN edge.
  - out_valid=0 is the only validity indicator; the bench must not check result outside DONE.
- in_valid during RUN or DONE is ignored. Operands are not re-sampled and no error is flagged.
- WIDTH=1: accept -> one RUN edge -> DONE.
- Counter width is clog2(WIDTH+1). There is no wrap-around beyond WIDTH-1.
- out_ready asserted in IDLE/RUN has no effect.
- Arithmetic is unsigned. The signed difference equals result interpreted as two's complement; overflow is not flagged.

Test Plan:
- Reset, then check all outputs -> in_ready=1, out_valid=0, result=0, borrow=0.
- WIDTH=8: value_1=5, value_2=3, in_valid one cycle, out_ready=1 -> out_valid rises exactly 8 cycles after acceptance; result=8'h02, borrow=0; back to IDLE next edge.
- value_1=3, value_2=5 -> result=8'hFE, borrow=1. Also check 0-1 -> 8'hFF, borrow=1; 0-0 -> 8'h00, borrow=0; 8'hFF-8'hFF -> 8'h00, borrow=0.
- Backpressure: out_ready=0 for 5 cycles after DONE -> out_valid stays 1, result/borrow stable, in_ready=0, and in_valid pulses with new operands are ignored. Then out_ready=1 -> IDLE.
- Reset mid-operation: assert rst at the 4th RUN edge of 8'hA0-8'h0F -> IDLE next cycle with all outputs zero. A following 8'hA0-8'h0F completes with result=8'h91, borrow=0.
- Back-to-back with in_valid held high: three operations (10-4, 4-10, 200-100) with out_ready=1 -> results 8'h06/0, 8'hFA/1, 8'h64/0 in order, each spaced WIDTH+2 cycles apart. Repeat a random 200-vector sweep against a reference model; also run at WIDTH=1 and WIDTH=16.
